// File: rtl/clk_activity_monitor.sv
// rtl/clk_activity_monitor.sv - measures i_mon_clk period in i_ahb_clk cycles, tracks lock and flags errors
module clk_activity_monitor #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_CNT    = 4
) (
   input  logic             i_ahb_clk,
   input  logic             i_ahb_rst_n,
   input  logic             i_mon_clk,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_min_cnt,
   input  logic [CNT_W-1:0] i_max_cnt,
   input  logic [CNT_W-1:0] i_timeout_cnt,
   output logic [CNT_W-1:0] o_period_cnt,
   output logic             o_period_vld,
   output logic             o_lock,
   output logic             o_err_fast,
   output logic             o_err_slow,
   output logic             o_loss,
   output logic [2:0]       o_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACQ    = 3'd1,
      MEAS   = 3'd2,
      LOCKED = 3'd3,
      LOST   = 3'd4
   } state_t;

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   rise;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W:0]         cnt_inc;
   logic [CNT_W-1:0]       cnt_sat;
   logic [GOOD_W-1:0]      good_cnt;
   logic [GOOD_W-1:0]      good_inc;
   logic                   lock_now;
   logic                   timeout_hit;
   logic                   too_fast;
   logic                   too_slow;

   assign rise        = sync_q[SYNC_STAGES-1] & ~edge_q;
   assign cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
   // cnt_sat doubles as the measured period: cycles since the last rise, saturating
   assign cnt_sat     = cnt_inc[CNT_W] ? cnt : cnt_inc[CNT_W-1:0];
   assign timeout_hit = (i_timeout_cnt != '0) && (cnt_inc == {1'b0, i_timeout_cnt});
   assign too_fast    = cnt_sat < i_min_cnt;
   assign too_slow    = cnt_sat > i_max_cnt;
   assign good_inc    = (good_cnt == GOOD_W'(LOCK_CNT)) ? good_cnt : good_cnt + GOOD_W'(1);
   assign lock_now    = good_inc == GOOD_W'(LOCK_CNT);
   assign o_state     = state;

   always_ff @(posedge i_ahb_clk or negedge i_ahb_rst_n) begin
      if (!i_ahb_rst_n) begin
         state        <= IDLE;
         sync_q       <= '0;
         edge_q       <= 1'b0;
         cnt          <= '0;
         good_cnt     <= '0;
         o_period_cnt <= '0;
         o_period_vld <= 1'b0;
         o_lock       <= 1'b0;
         o_err_fast   <= 1'b0;
         o_err_slow   <= 1'b0;
         o_loss       <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], i_mon_clk};
         edge_q       <= sync_q[SYNC_STAGES-1];
         o_period_vld <= 1'b0;
         // clear first so that a flag-set later in this block overrides it
         if (i_clr) begin
            o_err_fast <= 1'b0;
            o_err_slow <= 1'b0;
            o_loss     <= 1'b0;
         end
         if (!i_en) begin
            state    <= IDLE;
            o_lock   <= 1'b0;
            cnt      <= '0;
            good_cnt <= '0;
         end else begin
            case (state)
               IDLE: state <= ACQ;
               ACQ: begin
                  if (rise) begin
                     state <= MEAS;
                     cnt   <= '0;
                  end else if (timeout_hit) begin
                     state    <= LOST;
                     o_loss   <= 1'b1;
                     cnt      <= '0;
                     good_cnt <= '0;
                  end else begin
                     cnt <= cnt_sat;
                  end
               end
               MEAS, LOCKED: begin
                  if (rise) begin
                     o_period_cnt <= cnt_sat;
                     o_period_vld <= 1'b1;
                     cnt          <= '0;
                     if (too_fast || too_slow) begin
                        if (too_fast) o_err_fast <= 1'b1;
                        if (too_slow) o_err_slow <= 1'b1;
                        good_cnt <= '0;
                        state    <= MEAS;
                        o_lock   <= 1'b0;
                     end else begin
                        good_cnt <= good_inc;
                        if (state == LOCKED || lock_now) begin
                           state  <= LOCKED;
                           o_lock <= 1'b1;
                        end
                     end
                  end else if (timeout_hit) begin
                     state    <= LOST;
                     o_lock   <= 1'b0;
                     o_loss   <= 1'b1;
                     cnt      <= '0;
                     good_cnt <= '0;
                  end else begin
                     cnt <= cnt_sat;
                  end
               end
               LOST: begin
                  if (rise) begin
                     state <= MEAS;
                     cnt   <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
